updown_debounce_counter: RTL

UPDOWN_DEBOUNCE_COUNTER -- requirements
Module: updown_debounce_counter

---
 rtl/updown_debounce_counter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/updown_debounce_counter.sv
// updown_debounce_counter
//   Debounced up/down push-button counter with wrap or saturate behaviour.
//   Each button is synchronised by two flops, then debounced: the accepted
//   level changes only after DB_CYCLES consecutive disagreeing clocks. A
//   debounced rising edge produces one registered event pulse and moves the
//   count.
//
//   Optional feature macro: AUTOREPEAT_EN. When defined, a held button emits
//   an extra event every REPEAT_CYCLES clocks after its initial press event.
//   When undefined, no repeat logic exists and REPEAT_CYCLES is ignored.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   countup     in   raw increment button (asynchronous, bouncing)
//   countdown   in   raw decrement button (asynchronous, bouncing)
//   count       out  [WIDTH-1:0] current count, registered
//   up_pulse    out  one-cycle strobe per accepted increment event
//   down_pulse  out  one-cycle strobe per accepted decrement event
//   at_max      out  count == MAX_COUNT (combinational)
//   at_min      out  count == 0 (combinational)

// One button channel: synchroniser, debouncer, edge detect, optional repeat.
module updown_debounce_channel #(
   parameter int unsigned DB_CYCLES     = 4,
   parameter int unsigned REPEAT_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic event_c
);

   localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   logic           meta;
   logic           sync;
   logic           db;
   logic           db_q;
   logic [DBW-1:0] stab;
   logic           press_c;

   // Synchroniser, stability counter and debounced level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         db   <= 1'b0;
         db_q <= 1'b0;
         stab <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         db_q <= db;
         if (sync != db) begin
            if (stab == DB_LAST) begin
               db   <= sync;
               stab <= '0;
            end else begin
               stab <= stab + DBW'(1);
            end
         end else begin
            // Any agreeing cycle throws away partial progress.
            stab <= '0;
         end
      end
   end

   assign press_c = db & ~db_q;

`ifdef AUTOREPEAT_EN
   localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep;

   // Repeat interval counter; runs only while the level has been high for
   // more than one cycle, so it restarts from zero at each press event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep <= '0;
      end else if (!(db && db_q)) begin
         rep <= '0;
      end else if (rep == REP_LAST) begin
         rep <= '0;
      end else begin
         rep <= rep + RW'(1);
      end
   end

   assign event_c = press_c | (db & db_q & (rep == REP_LAST));
`else
   assign event_c = press_c;
`endif

endmodule

module updown_debounce_counter #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned MAX_COUNT     = 15,
   parameter int unsigned DB_CYCLES     = 4,
   parameter int unsigned WRAP          = 1,
   parameter int unsigned REPEAT_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             countup,
   input  logic             countdown,
   output logic [WIDTH-1:0] count,
   output logic             up_pulse,
   output logic             down_pulse,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   logic             up_ev_c;
   logic             down_ev_c;
   logic [WIDTH-1:0] count_nxt_c;

   updown_debounce_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_up (
      .clock   (clock),
      .reset   (reset),
      .raw     (countup),
      .event_c (up_ev_c)
   );

   updown_debounce_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_down (
      .clock   (clock),
      .reset   (reset),
      .raw     (countdown),
      .event_c (down_ev_c)
   );

   // Next count: simultaneous up and down cancel out.
   always_comb begin
      count_nxt_c = count;
      if (up_ev_c && !down_ev_c) begin
         if (count == MAX_VAL) begin
            count_nxt_c = (WRAP != 0) ? '0 : MAX_VAL;
         end else begin
            count_nxt_c = count + WIDTH'(1);
         end
      end else if (down_ev_c && !up_ev_c) begin
         if (count == '0) begin
            count_nxt_c = (WRAP != 0) ? MAX_VAL : '0;
         end else begin
            count_nxt_c = count - WIDTH'(1);
         end
      end
   end

   // Count and event strobes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count      <= '0;
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
      end else begin
         count      <= count_nxt_c;
         up_pulse   <= up_ev_c;
         down_pulse <= down_ev_c;
      end
   end

   assign at_max = (count == MAX_VAL);
   assign at_min = (count == '0);

endmodule
